// File: rtl/interrupt_flag_unit.sv
// -----------------------------------------------------------------------------
// interrupt_flag_unit
//
// Interrupt flag (IF) / interrupt enable (IE) controller. Peripheral request
// levels are edge-detected and latched into IF. IF is masked by IE to form
// the pending-interrupt vector for the CPU control unit. A rising edge on the
// control unit's acknowledge clears the highest-priority pending flag. The
// CPU reads and writes IF and IE through a simple memory-mapped bus port.
//
// Ports:
//   i_Clk              system clock, rising edge
//   i_nRst             asynchronous active-low reset
//   i_Enable           clock enable; all state holds while low
//   i_Request[4:0]     request levels (0 VBlank, 1 STAT, 2 Timer, 3 Serial,
//                      4 Joypad)
//   i_Handle_Interrupt acknowledge level from the control unit
//   o_Interrupts[4:0]  IF & IE[4:0]
//   i_Address[15:0]    CPU address bus
//   i_Data[7:0]        CPU write data
//   i_Bus_Out          CPU write strobe
//   i_Bus_In           CPU read strobe
//   o_Data[7:0]        read data, 8'h00 when not selected
//   o_Data_Active      high when this block drives o_Data
// -----------------------------------------------------------------------------
module interrupt_flag_unit #(
    parameter logic [15:0] IF_ADDR = 16'hFF0F,
    parameter logic [15:0] IE_ADDR = 16'hFFFF
) (
    input  logic        i_Clk,
    input  logic        i_nRst,
    input  logic        i_Enable,
    input  logic [4:0]  i_Request,
    input  logic        i_Handle_Interrupt,
    output logic [4:0]  o_Interrupts,
    input  logic [15:0] i_Address,
    input  logic [7:0]  i_Data,
    input  logic        i_Bus_Out,
    input  logic        i_Bus_In,
    output logic [7:0]  o_Data,
    output logic        o_Data_Active
);

    logic [4:0] if_q;
    logic [7:0] ie_q;
    logic [4:0] req_prev;
    logic       ack_prev;

    logic [4:0] req_edge;
    logic       ack_edge;
    logic [4:0] pending;
    logic [4:0] ack_clear;
    logic [4:0] if_next;
    logic       if_wr;
    logic       ie_wr;
    logic       if_rd;
    logic       ie_rd;

    // Isolate the lowest set bit: lowest index is the highest priority.
    function automatic logic [4:0] lowest_set(input logic [4:0] v);
        return v & (~v + 5'd1);
    endfunction

    always_comb begin
        req_edge  = i_Request & ~req_prev;
        ack_edge  = i_Handle_Interrupt & ~ack_prev;
        pending   = if_q & ie_q[4:0];
        // Chosen from pre-update IF/IE, so a same-cycle IF write cannot
        // redirect which flag the acknowledge retires.
        ack_clear = ack_edge ? lowest_set(pending) : 5'd0;
        if_wr     = i_Bus_Out && (i_Address == IF_ADDR);
        ie_wr     = i_Bus_Out && (i_Address == IE_ADDR);
        // Write data (or held IF), minus the acknowledged bit, plus new
        // request edges: a fresh request always survives.
        if_next   = ((if_wr ? i_Data[4:0] : if_q) & ~ack_clear) | req_edge;
    end

    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            if_q     <= 5'd0;
            ie_q     <= 8'd0;
            req_prev <= 5'd0;
            ack_prev <= 1'b0;
        end else if (i_Enable) begin
            if_q     <= if_next;
            if (ie_wr) begin
                ie_q <= i_Data;
            end
            req_prev <= i_Request;
            ack_prev <= i_Handle_Interrupt;
        end
    end

    assign o_Interrupts = if_q & ie_q[4:0];

    always_comb begin
        if_rd         = i_Bus_In && (i_Address == IF_ADDR);
        ie_rd         = i_Bus_In && (i_Address == IE_ADDR);
        o_Data        = 8'h00;
        o_Data_Active = 1'b0;
        if (if_rd) begin
            // Unimplemented upper IF bits read back as ones.
            o_Data        = {3'b111, if_q};
            o_Data_Active = 1'b1;
        end else if (ie_rd) begin
            o_Data        = ie_q;
            o_Data_Active = 1'b1;
        end
    end

endmodule

// File: tb/tb_interrupt_flag_unit.sv
module tb_interrupt_flag_unit;

    logic        clk;
    logic        nrst;
    logic        en;
    logic [4:0]  req;
    logic        hack;
    logic [4:0]  irq;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        bout;
    logic        bin;
    logic [7:0]  rdata;
    logic        ractive;

    int compared;
    int mismatched;

    // Reference model state
    logic [7:0] m_if;
    logic [7:0] m_ie;
    logic [4:0] m_req_prev;
    logic       m_ack_prev;

    interrupt_flag_unit #(
        .IF_ADDR(16'hFF0F),
        .IE_ADDR(16'hFFFF)
    ) dut (
        .i_Clk              (clk),
        .i_nRst             (nrst),
        .i_Enable           (en),
        .i_Request          (req),
        .i_Handle_Interrupt (hack),
        .o_Interrupts       (irq),
        .i_Address          (addr),
        .i_Data             (wdata),
        .i_Bus_Out          (bout),
        .i_Bus_In           (bin),
        .o_Data             (rdata),
        .o_Data_Active      (ractive)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_if       = 8'h00;
        m_ie       = 8'h00;
        m_req_prev = 5'h00;
        m_ack_prev = 1'b0;
    endtask

    // One clock of the rules, applied to the inputs held across the edge.
    task automatic model_update();
        logic [7:0] nxt;
        logic [7:0] pend;
        if (!nrst) begin
            model_reset();
            return;
        end
        if (!en) return;
        nxt  = (bout && addr == 16'hFF0F) ? (wdata & 8'h1F) : m_if;
        pend = m_if & m_ie & 8'h1F;
        if (hack && !m_ack_prev) begin
            for (int n = 0; n < 5; n++) begin
                if (pend[n]) begin
                    nxt[n] = 1'b0;
                    break;
                end
            end
        end
        for (int n = 0; n < 5; n++) begin
            if (req[n] && !m_req_prev[n]) nxt[n] = 1'b1;
        end
        if (bout && addr == 16'hFFFF) m_ie = wdata;
        m_if       = nxt;
        m_req_prev = req;
        m_ack_prev = hack;
    endtask

    task automatic check_outputs();
        logic [7:0] exp_d;
        logic       exp_a;
        exp_d = 8'h00;
        exp_a = 1'b0;
        if (bin && addr == 16'hFF0F) begin
            exp_d = 8'hE0 | m_if;
            exp_a = 1'b1;
        end else if (bin && addr == 16'hFFFF) begin
            exp_d = m_ie;
            exp_a = 1'b1;
        end
        chk("model_irq", {3'b000, irq}, m_if & m_ie & 8'h1F);
        chk("model_rdata", rdata, exp_d);
        chk("model_ractive", {7'd0, ractive}, {7'd0, exp_a});
    endtask

    // Check at the falling edge, clock, then step 1ns past the rising edge.
    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        bout  = 1'b1;
        tick();
        bout  = 1'b0;
    endtask

    task automatic bus_read_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
        addr = a;
        bin  = 1'b1;
        #1;
        chk(tag, rdata, exp);
        chk({tag, "_act"}, {7'd0, ractive}, 8'h01);
        bin  = 1'b0;
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        nrst  = 1'b0;
        en    = 1'b1;
        req   = 5'h00;
        hack  = 1'b0;
        addr  = 16'h0000;
        wdata = 8'h00;
        bout  = 1'b0;
        bin   = 1'b0;
        model_reset();

        // Reset state
        #2;
        chk("reset_irq", {3'b000, irq}, 8'h00);
        chk("reset_rdata", rdata, 8'h00);
        chk("reset_ractive", {7'd0, ractive}, 8'h00);
        tick();
        nrst = 1'b1;
        tick();

        // IE=05, pulse Timer request
        bus_write(16'hFFFF, 8'h05);
        req[2] = 1'b1;
        tick();
        req[2] = 1'b0;
        chk("timer_irq", {3'b000, irq}, 8'h04);
        bus_read_chk("timer_if_read", 16'hFF0F, 8'hE4);
        tick();

        // Held VBlank request sets IF once; write of 0 on cycle 3 sticks
        bus_write(16'hFFFF, 8'h1F);
        req[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                addr  = 16'hFF0F;
                wdata = 8'h00;
                bout  = 1'b1;
            end else begin
                bout  = 1'b0;
            end
            tick();
            if (i == 0) chk("hold_first_set", {3'b000, irq}, 8'h05);
            if (i == 3) chk("hold_after_clear", {3'b000, irq}, 8'h00);
        end
        chk("hold_no_reset", {3'b000, irq}, 8'h00);
        req[0] = 1'b0;
        tick();

        // Acknowledge held 4 cycles clears only the lowest pending bit
        bus_write(16'hFF0F, 8'h1A);
        hack = 1'b1;
        tick();
        chk("ack_first", {3'b000, irq}, 8'h18);
        for (int i = 0; i < 3; i++) tick();
        chk("ack_held", {3'b000, irq}, 8'h18);
        hack = 1'b0;
        tick();

        // Same cycle: IF write 0, Joypad edge, acknowledge
        bus_write(16'hFFFF, 8'h01);
        bus_write(16'hFF0F, 8'h01);
        addr  = 16'hFF0F;
        wdata = 8'h00;
        bout  = 1'b1;
        req[4] = 1'b1;
        hack  = 1'b1;
        tick();
        bout  = 1'b0;
        req[4] = 1'b0;
        hack  = 1'b0;
        bus_read_chk("priority_if", 16'hFF0F, 8'hF0);
        tick();

        // Edge seen only while disabled is lost
        bus_write(16'hFF0F, 8'h00);
        en = 1'b0;
        req[1] = 1'b1;
        tick();
        req[1] = 1'b0;
        tick();
        en = 1'b1;
        tick();
        bus_read_chk("disabled_lost", 16'hFF0F, 8'hE0);

        // Asynchronous reset mid-cycle
        bus_write(16'hFFFF, 8'hFF);
        bus_write(16'hFF0F, 8'h1F);
        chk("pre_reset_irq", {3'b000, irq}, 8'h1F);
        #2;
        nrst = 1'b0;
        model_reset();
        #1;
        chk("async_reset_irq", {3'b000, irq}, 8'h00);
        bus_read_chk("async_reset_ie", 16'hFFFF, 8'h00);
        tick();
        nrst = 1'b1;
        tick();

        // Randomized phase against the model
        for (int c = 0; c < 3000; c++) begin
            en   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) req = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) hack = ~hack;
            case ($urandom_range(0, 3))
                0: addr = 16'hFF0F;
                1: addr = 16'hFFFF;
                2: addr = 16'hFF0E;
                default: addr = 16'($urandom);
            endcase
            wdata = 8'($urandom);
            bout  = ($urandom_range(0, 3) == 0);
            bin   = ($urandom_range(0, 1) == 0);
            if (nrst && $urandom_range(0, 63) == 0) begin
                nrst = 1'b0;
                model_reset();
            end else begin
                nrst = 1'b1;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
